// File: rtl/payment_collector_pkg.sv
// Shared types, constants and helpers for the payment collector front end.
// Defines the state encoding, note codes, money width and note/price decoding helpers.
package payment_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PAID    = 2'd2,
        ST_REFUND  = 2'd3
    } state_t;

    localparam logic [1:0] NOTE_10   = 2'd1;
    localparam logic [1:0] NOTE_20   = 2'd2;
    localparam int         MONEY_W   = 5;
    localparam int         MAX_MONEY = 30;

    function automatic logic [MONEY_W-1:0] note_value(input logic [1:0] code);
        logic [MONEY_W-1:0] value;
        case (code)
            NOTE_10: value = 5'd10;
            NOTE_20: value = 5'd20;
            default: value = 5'd0;
        endcase
        return value;
    endfunction

    function automatic logic note_is_legal(input logic [1:0] code);
        return (code == NOTE_10) || (code == NOTE_20);
    endfunction

    // A price is usable only if it is non-zero, affordable and payable in whole notes.
    function automatic logic price_is_legal(input logic [MONEY_W-1:0] p,
                                            input logic [MONEY_W-1:0] max_money,
                                            input logic [MONEY_W-1:0] unit);
        return (p != {MONEY_W{1'b0}}) && (p <= max_money) &&
               ((p % unit) == {MONEY_W{1'b0}});
    endfunction

endpackage

// File: rtl/payment_timeout_timer.sv
// Idle timer for the collect phase: counts enabled cycles and flags the last one.
// Saturates at its terminal count so the expired flag stays valid until cleared.
module payment_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] count_r;

    // Idle-cycle counter; clear has priority over counting
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {TIMER_W{1'b0}};
        end else if (clear) begin
            count_r <= {TIMER_W{1'b0}};
        end else if (enable && (count_r != LAST_COUNT)) begin
            count_r <= count_r + {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == LAST_COUNT);

endmodule

// File: rtl/payment_collector.sv
// Payment collector: latches a price, accumulates 10/20 notes, then pays out change or refunds.
// FSM and accumulator live here; the idle timeout is delegated to payment_timeout_timer.
module payment_collector
    import payment_collector_pkg::*;
#(
    parameter int MAX_MONEY      = 30,
    parameter int NOTE_UNIT      = 10,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MONEY_W-1:0] price,
    input  logic               noteValid,
    input  logic [1:0]         noteCode,
    input  logic               cancel,
    input  logic               refundAck,
    output logic [MONEY_W-1:0] inputMoney,
    output logic               noteAccept,
    output logic               noteReject,
    output logic               badPrice,
    output logic               paid,
    output logic               refundReq,
    output logic [MONEY_W-1:0] refundMoney,
    output logic               busy
);

    localparam logic [MONEY_W-1:0] MAX_M   = MONEY_W'(MAX_MONEY);
    localparam logic [MONEY_W-1:0] UNIT    = MONEY_W'(NOTE_UNIT);
    localparam logic [MONEY_W:0]   MAX_SUM = (MONEY_W+1)'(MAX_MONEY);

    state_t             state_r;
    logic [MONEY_W-1:0] price_r;
    logic [MONEY_W:0]   sum_s;
    logic [MONEY_W-1:0] change_s;
    logic               in_collect_s;
    logic               pay_due_s;
    logic               note_fits_s;
    logic               accept_s;
    logic               start_ok_s;
    logic               timer_clear_s;
    logic               timer_expired_s;
    logic               refund_now_s;

    // The sum is one bit wider so a 20 on top of 20 is seen as overflow, not wrap.
    assign sum_s         = {1'b0, inputMoney} + {1'b0, note_value(noteCode)};
    assign note_fits_s   = note_is_legal(noteCode) && (sum_s <= MAX_SUM);
    assign start_ok_s    = price_is_legal(price, MAX_M, UNIT);
    assign in_collect_s  = (state_r == ST_COLLECT);
    assign pay_due_s     = (inputMoney >= price_r);
    assign change_s      = inputMoney - price_r;
    assign accept_s      = in_collect_s && noteValid && !pay_due_s && !cancel && note_fits_s;
    assign timer_clear_s = !in_collect_s || accept_s;
    assign refund_now_s  = cancel || (timer_expired_s && !accept_s);

    payment_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_W        (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .enable  (in_collect_s),
        .expired (timer_expired_s)
    );

    // Transaction FSM with accumulator and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            price_r     <= {MONEY_W{1'b0}};
            inputMoney  <= {MONEY_W{1'b0}};
            refundMoney <= {MONEY_W{1'b0}};
            noteAccept  <= 1'b0;
            noteReject  <= 1'b0;
            badPrice    <= 1'b0;
            paid        <= 1'b0;
            refundReq   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            noteAccept <= 1'b0;
            noteReject <= 1'b0;
            badPrice   <= 1'b0;
            paid       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    noteReject <= noteValid;
                    if (start && start_ok_s) begin
                        price_r <= price;
                        state_r <= ST_COLLECT;
                        busy    <= 1'b1;
                    end else if (start) begin
                        badPrice <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (pay_due_s) begin
                        noteReject <= noteValid;
                        paid       <= 1'b1;
                        state_r    <= ST_PAID;
                    end else begin
                        if (accept_s) begin
                            inputMoney <= sum_s[MONEY_W-1:0];
                            noteAccept <= 1'b1;
                        end else begin
                            noteReject <= noteValid;
                        end
                        // Nothing collected means nothing to dispense: go straight home.
                        if (refund_now_s && (inputMoney == {MONEY_W{1'b0}})) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end else if (refund_now_s) begin
                            refundMoney <= inputMoney;
                            refundReq   <= 1'b1;
                            state_r     <= ST_REFUND;
                        end
                    end
                end
                ST_PAID: begin
                    noteReject <= noteValid;
                    if (change_s == {MONEY_W{1'b0}}) begin
                        inputMoney <= {MONEY_W{1'b0}};
                        state_r    <= ST_IDLE;
                        busy       <= 1'b0;
                    end else begin
                        refundMoney <= change_s;
                        refundReq   <= 1'b1;
                        state_r     <= ST_REFUND;
                    end
                end
                ST_REFUND: begin
                    noteReject <= noteValid;
                    if (refundReq && refundAck) begin
                        inputMoney  <= {MONEY_W{1'b0}};
                        refundMoney <= {MONEY_W{1'b0}};
                        refundReq   <= 1'b0;
                        state_r     <= ST_IDLE;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_payment_collector.sv
// Self-checking bench for payment_collector: vector table fed through an expected-result
// queue, plus hand-written timeout sequences with bounded waits.
module tb_payment_collector;

    logic       clk;
    logic       reset;
    logic       start;
    logic [4:0] price;
    logic       noteValid;
    logic [1:0] noteCode;
    logic       cancel;
    logic       refundAck;
    logic [4:0] inputMoney;
    logic       noteAccept;
    logic       noteReject;
    logic       badPrice;
    logic       paid;
    logic       refundReq;
    logic [4:0] refundMoney;
    logic       busy;

    payment_collector #(
        .MAX_MONEY      (30),
        .NOTE_UNIT      (10),
        .TIMEOUT_CYCLES (8),
        .TIMER_W        (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .price       (price),
        .noteValid   (noteValid),
        .noteCode    (noteCode),
        .cancel      (cancel),
        .refundAck   (refundAck),
        .inputMoney  (inputMoney),
        .noteAccept  (noteAccept),
        .noteReject  (noteReject),
        .badPrice    (badPrice),
        .paid        (paid),
        .refundReq   (refundReq),
        .refundMoney (refundMoney),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {inputMoney, accept, reject, bad, paid, req, refundMoney, busy}
    typedef struct packed {
        logic [4:0] im;
        logic       acc;
        logic       rej;
        logic       bad;
        logic       pd;
        logic       req;
        logic [4:0] rm;
        logic       busy;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       st;
        logic [4:0] pr;
        logic       nv;
        logic [1:0] code;
        logic       cn;
        logic       ack;
        exp_t       exp;
    } vec_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   tests;
    int   fails;

    function automatic vec_t mk(input logic rst, input logic st, input logic [4:0] pr,
                                input logic nv, input logic [1:0] code, input logic cn,
                                input logic ack, input logic [4:0] im, input logic acc,
                                input logic rej, input logic bad, input logic pd,
                                input logic req, input logic [4:0] rm, input logic bsy);
        vec_t v;
        v.rst = rst; v.st = st; v.pr = pr; v.nv = nv; v.code = code; v.cn = cn; v.ack = ack;
        v.exp = '{im: im, acc: acc, rej: rej, bad: bad, pd: pd, req: req, rm: rm, busy: bsy};
        return v;
    endfunction

    function automatic exp_t sample();
        return '{im: inputMoney, acc: noteAccept, rej: noteReject, bad: badPrice,
                 pd: paid, req: refundReq, rm: refundMoney, busy: busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int actual, input int required);
        tests++;
        if (actual != required) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, actual, required);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; start = 1'b0; price = 5'd0; noteValid = 1'b0;
        noteCode = 2'd0; cancel = 1'b0; refundAck = 1'b0;
    endtask

    initial begin
        vec_t v;
        exp_t got;
        exp_t e;
        int   cycles;
        int   saw_req;
        tests = 0;
        fails = 0;
        idle_inputs();
        reset = 1'b1;

        //              rst   st    pr     nv    cd    cn    ack   im     acc   rej   bad   pd    req   rm     busy
        // reset
        vecs.push_back(mk(1'b1,1'b0,5'd0, 1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0));
        // price 20, notes 10 + 10, exact payment
        vecs.push_back(mk(1'b0,1'b1,5'd20,1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,2'd1,1'b0,1'b0,5'd10,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,2'd1,1'b0,1'b0,5'd20,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,2'd0,1'b0,1'b0,5'd20,1'b0,1'b0,1'b0,1'b1,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0));
        // price 10, note 20: change 10 held for five cycles until ack
        vecs.push_back(mk(1'b0,1'b1,5'd10,1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,2'd2,1'b0,1'b0,5'd20,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,2'd0,1'b0,1'b0,5'd20,1'b0,1'b0,1'b0,1'b1,1'b0,5'd0, 1'b1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b0,1'b0,5'd0,1'b0,2'd0,1'b0,1'b0,5'd20,1'b0,1'b0,1'b0,1'b0,1'b1,5'd10,1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,2'd0,1'b0,1'b1,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0));
        // price 30, start in COLLECT ignored, 20 + 20 overflows, then 10
        vecs.push_back(mk(1'b0,1'b1,5'd30,1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b1,5'd10,1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,2'd2,1'b0,1'b0,5'd20,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,2'd2,1'b0,1'b0,5'd20,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,2'd1,1'b0,1'b0,5'd30,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,2'd0,1'b0,1'b0,5'd30,1'b0,1'b0,1'b0,1'b1,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0));
        // price 30, note 10, cancel with a 20 in the same cycle
        vecs.push_back(mk(1'b0,1'b1,5'd30,1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,2'd1,1'b0,1'b0,5'd10,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,2'd2,1'b1,1'b0,5'd10,1'b0,1'b1,1'b0,1'b0,1'b1,5'd10,1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,2'd0,1'b1,1'b0,5'd10,1'b0,1'b0,1'b0,1'b0,1'b1,5'd10,1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,2'd1,1'b0,1'b0,5'd10,1'b0,1'b1,1'b0,1'b0,1'b1,5'd10,1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,2'd0,1'b0,1'b1,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,2'd0,1'b0,1'b1,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0));
        // illegal prices and a note while idle
        vecs.push_back(mk(1'b0,1'b1,5'd15,1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0));
        vecs.push_back(mk(1'b0,1'b1,5'd0, 1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0));
        vecs.push_back(mk(1'b0,1'b1,5'd31,1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,5'd0, 1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,2'd1,1'b0,1'b0,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 1'b0));
        // cancel with nothing inserted returns straight to idle
        vecs.push_back(mk(1'b0,1'b1,5'd10,1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,2'd0,1'b1,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0));
        // illegal codes in COLLECT, then reset mid-transaction
        vecs.push_back(mk(1'b0,1'b1,5'd30,1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,2'd2,1'b0,1'b0,5'd20,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,2'd3,1'b0,1'b0,5'd20,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b1,2'd0,1'b0,1'b0,5'd20,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0, 1'b1));
        vecs.push_back(mk(1'b1,1'b0,5'd0, 1'b1,2'd1,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0));
        vecs.push_back(mk(1'b0,1'b0,5'd0, 1'b0,2'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            reset = v.rst; start = v.st; price = v.pr; noteValid = v.nv;
            noteCode = v.code; cancel = v.cn; refundAck = v.ack;
            exp_q.push_back(v.exp);
            tick();
            got = sample();
            e = exp_q.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL vec%0d: got im=%0d acc=%b rej=%b bad=%b paid=%b req=%b rm=%0d busy=%b expected im=%0d acc=%b rej=%b bad=%b paid=%b req=%b rm=%0d busy=%b",
                         i, got.im, got.acc, got.rej, got.bad, got.pd, got.req, got.rm, got.busy,
                         e.im, e.acc, e.rej, e.bad, e.pd, e.req, e.rm, e.busy);
            end
        end
        idle_inputs();

        // Timeout after one 10-note: refund request on the 8th idle cycle.
        start = 1'b1; price = 5'd20;
        tick();
        idle_inputs();
        noteValid = 1'b1; noteCode = 2'd1;
        tick();
        idle_inputs();
        check_val("timeout_accept", int'(noteAccept), 1);
        cycles = 0;
        while (!refundReq && cycles < 20) begin
            tick();
            cycles++;
        end
        check_val("timeout_cycles", cycles, 8);
        check_val("timeout_refund_money", int'(refundMoney), 10);
        check_val("timeout_input_money", int'(inputMoney), 10);
        refundAck = 1'b1;
        tick();
        idle_inputs();
        check_val("timeout_ack_busy", int'(busy), 0);
        check_val("timeout_ack_req", int'(refundReq), 0);

        // Timeout with nothing inserted: back to idle without any request.
        start = 1'b1; price = 5'd10;
        tick();
        idle_inputs();
        saw_req = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (refundReq) saw_req = 1;
        end
        check_val("empty_timeout_busy_before", int'(busy), 1);
        tick();
        if (refundReq) saw_req = 1;
        check_val("empty_timeout_busy_after", int'(busy), 0);
        check_val("empty_timeout_no_req", saw_req, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
